// File: rtl/fir_sequencer.sv
// Host-side issuer for the FIR controller dr/lc/modwait handshake.
// Buffers host coefficient/sample words, drives dr/lc and returns each result with its err flag.
//
// state   | meaning
// IDLE    | waiting for a host coefficient or sample
// LC_REQ  | lc held high until the controller raises modwait
// LC_BUSY | coefficient load in progress, waiting for modwait low
// DR_REQ  | dr held high until the controller raises modwait (covers STORE)
// DR_BUSY | filter computation in progress, waiting for modwait low
// RESULT  | result held for the host until result_ready
module fir_sequencer #(
  parameter int DATA_W    = 16,
  parameter int NUM_COEFF = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              coeff_valid,
  input  logic [DATA_W-1:0] coeff_in,
  output logic              coeff_ready,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              sample_ready,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_out,
  output logic              result_err,
  output logic              timeout_err,
  output logic              dr,
  output logic              lc,
  output logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] fir_coefficient,
  input  logic              modwait,
  input  logic              err,
  input  logic [DATA_W-1:0] fir_out
);

  localparam int IDX_W = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LC_REQ, LC_BUSY, DR_REQ, DR_BUSY, RESULT} state_t;

  state_t              r_state, w_next;
  logic [TMR_W-1:0]    r_timer;
  logic [IDX_W-1:0]    r_coeff_idx;
  logic                r_coeffs_loaded;
  logic                r_dr, r_lc, r_result_valid, r_timeout_err, r_result_err;
  logic [DATA_W-1:0]   r_sample, r_coeff, r_result;
  logic                w_coeff_acc, w_sample_acc, w_in_hs, w_tmo_hit, w_tmo_fire;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Progress on modwait wins over a timeout landing on the same cycle.
  always_comb begin
    w_next     = r_state;
    w_tmo_fire = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_coeff_acc)       w_next = LC_REQ;
        else if (w_sample_acc) w_next = DR_REQ;
      end
      LC_REQ: begin
        if (modwait)        w_next = LC_BUSY;
        else if (w_tmo_hit) begin w_next = IDLE; w_tmo_fire = 1'b1; end
      end
      LC_BUSY: begin
        if (!modwait)       w_next = IDLE;
        else if (w_tmo_hit) begin w_next = IDLE; w_tmo_fire = 1'b1; end
      end
      DR_REQ: begin
        if (modwait)        w_next = DR_BUSY;
        else if (w_tmo_hit) begin w_next = IDLE; w_tmo_fire = 1'b1; end
      end
      DR_BUSY: begin
        if (!modwait)       w_next = RESULT;
        else if (w_tmo_hit) begin w_next = IDLE; w_tmo_fire = 1'b1; end
      end
      RESULT: begin
        if (result_ready)   w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    coeff_ready  = 1'b0;
    sample_ready = 1'b0;
    if (r_state == IDLE) begin
      coeff_ready  = !modwait;
      sample_ready = !modwait && r_coeffs_loaded && (r_coeff_idx == '0);
    end
    w_coeff_acc  = coeff_valid && coeff_ready;
    w_sample_acc = sample_valid && sample_ready && !w_coeff_acc;
    w_in_hs      = (r_state == LC_REQ) || (r_state == LC_BUSY) ||
                   (r_state == DR_REQ) || (r_state == DR_BUSY);
    w_tmo_hit    = w_in_hs && (r_timer == TMR_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_timer <= '0;
    end else if ((w_next != r_state) || !w_in_hs) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_dr           <= 1'b0;
      r_lc           <= 1'b0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_dr           <= (w_next == DR_REQ);
      r_lc           <= (w_next == LC_REQ);
      r_result_valid <= (w_next == RESULT);
      if (w_tmo_fire) r_timeout_err <= 1'b1;
    end
  end

  // A coefficient only counts once its load completes, so a timed-out one is retried.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_coeff_idx     <= '0;
      r_coeffs_loaded <= 1'b0;
    end else if ((r_state == LC_BUSY) && !modwait) begin
      if (r_coeff_idx == IDX_W'(NUM_COEFF - 1)) begin
        r_coeff_idx     <= '0;
        r_coeffs_loaded <= 1'b1;
      end else begin
        r_coeff_idx <= r_coeff_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sample     <= '0;
      r_coeff      <= '0;
      r_result     <= '0;
      r_result_err <= 1'b0;
    end else begin
      if (w_sample_acc) r_sample <= sample_in;
      if (w_coeff_acc)  r_coeff  <= coeff_in;
      if ((r_state == DR_BUSY) && !modwait) begin
        r_result     <= fir_out;
        r_result_err <= err;
      end
    end
  end

  assign dr              = r_dr;
  assign lc              = r_lc;
  assign result_valid    = r_result_valid;
  assign result_out      = r_result;
  assign result_err      = r_result_err;
  assign timeout_err     = r_timeout_err;
  assign sample_data     = r_sample;
  assign fir_coefficient = r_coeff;

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with a small behavioural FIR controller model
// answering dr/lc with modwait (normal, early-error and stuck modes).
module tb_fir_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        coeff_valid = 1'b0, sample_valid = 1'b0, result_ready = 1'b0;
  logic [15:0] coeff_in = '0, sample_in = '0, fir_out = '0;
  logic        coeff_ready, sample_ready, result_valid, result_err, timeout_err, dr, lc;
  logic [15:0] result_out, sample_data, fir_coefficient;
  logic        modwait, err;

  int n_chk = 0;
  int n_bad = 0;

  fir_sequencer #(.DATA_W(16), .NUM_COEFF(4), .TIMEOUT(15)) dut (
    .clk(clk), .n_rst(n_rst),
    .coeff_valid(coeff_valid), .coeff_in(coeff_in), .coeff_ready(coeff_ready),
    .sample_valid(sample_valid), .sample_in(sample_in), .sample_ready(sample_ready),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_out(result_out), .result_err(result_err), .timeout_err(timeout_err),
    .dr(dr), .lc(lc), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .modwait(modwait), .err(err), .fir_out(fir_out)
  );

  always #5 clk = ~clk;

  // controller model: 0 idle, 1 STORE/LOAD cycle, 2 busy
  int m_busy = 3;
  bit m_err_mode = 1'b0;
  bit m_stuck = 1'b0;
  int m_st, m_cnt;
  bit m_was_dr;
  int store_bad = 0, lc_late = 0, lc_pulses = 0;
  logic lc_prev = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_st <= 0; m_cnt <= 0; modwait <= 1'b0; err <= 1'b0; m_was_dr <= 1'b0;
    end else begin
      case (m_st)
        0: if (!m_stuck && (dr || lc)) begin
             m_st <= 1; modwait <= 1'b1; m_was_dr <= dr;
             if (dr) err <= 1'b0;
           end
        1: begin
             if (m_was_dr && !dr) store_bad <= store_bad + 1;
             if (m_was_dr && m_err_mode) begin
               err <= 1'b1; modwait <= 1'b0; m_st <= 0;
             end else begin
               m_st <= 2; m_cnt <= 1;
             end
           end
        default: begin
             if (lc) lc_late <= lc_late + 1;
             if (m_cnt >= m_busy - 1) begin
               modwait <= 1'b0; m_st <= 0;
             end else begin
               m_cnt <= m_cnt + 1;
             end
           end
      endcase
    end
  end

  always @(posedge clk) begin
    lc_prev <= lc;
    if (lc && !lc_prev) lc_pulses <= lc_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!coeff_ready && n < 60) begin @(negedge clk); n++; end
    chk(tag, (n < 60), 1);
  endtask

  task automatic send_coeff(input logic [15:0] v);
    wait_idle("coeff_wait");
    coeff_in = v; coeff_valid = 1'b1;
    @(posedge clk); #1;
    coeff_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] v);
    int n = 0;
    @(negedge clk);
    while (!sample_ready && n < 60) begin @(negedge clk); n++; end
    chk("sample_wait", (n < 60), 1);
    sample_in = v; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!result_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    chk("result_wait", (lat < 60), 1);
  endtask

  task automatic consume();
    @(negedge clk); result_ready = 1'b1;
    @(posedge clk); #1; result_ready = 1'b0;
    chk("rv_cleared", result_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, cnt;
    bit saw_dr, saw_rdy;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dr", dr, 0);
    chk("rst_lc", lc, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_tmo", timeout_err, 0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_coeff_rdy", coeff_ready, 1);
    chk("rst_sample_rdy", sample_ready, 0);

    // full coefficient set
    p0 = lc_pulses;
    for (int i = 1; i <= 4; i++) send_coeff(16'(i));
    wait_idle("load_idle");
    chk("lc_pulses", lc_pulses - p0, 4);
    chk("lc_late", lc_late, 0);
    chk("coef_last", fir_coefficient, 16'h0004);
    chk("loaded_rdy", sample_ready, 1);

    // normal sample; latency = 1 + 3 modwait-high cycles + 1
    fir_out = 16'h00A0;
    send_sample(16'h0010);
    chk("dr_after_acc", dr, 1);
    chk("sdata", sample_data, 16'h0010);
    wait_result(lat);
    chk("latency", lat, 5);
    chk("store_dr", store_bad, 0);
    chk("res_out", result_out, 16'h00A0);
    chk("res_err", result_err, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_rv", result_valid, 1);
    chk("hold_out", result_out, 16'h00A0);
    chk("pend_srdy", sample_ready, 0);
    consume();

    // coefficient wins over a simultaneous sample
    wait_idle("prio_idle");
    coeff_in = 16'h0005; coeff_valid = 1'b1;
    sample_in = 16'h0099; sample_valid = 1'b1;
    @(posedge clk); #1;
    coeff_valid = 1'b0; sample_valid = 1'b0;
    chk("prio_lc", lc, 1);
    chk("prio_dr", dr, 0);
    chk("prio_coef", fir_coefficient, 16'h0005);
    chk("prio_sdata", sample_data, 16'h0010);

    // partial set (idx=2) blocks samples
    send_coeff(16'h0006);
    wait_idle("part_idle");
    saw_dr = 1'b0; saw_rdy = 1'b0;
    sample_in = 16'h0077; sample_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sample_ready) saw_rdy = 1'b1;
      if (dr) saw_dr = 1'b1;
    end
    sample_valid = 1'b0;
    chk("part_srdy", saw_rdy, 0);
    chk("part_dr", saw_dr, 0);
    chk("part_crdy", coeff_ready, 1);
    send_coeff(16'h0007);
    send_coeff(16'h0008);
    wait_idle("reload_idle");
    chk("reload_coef", fir_coefficient, 16'h0008);
    chk("reload_srdy", sample_ready, 1);

    // controller error with early modwait drop, then a clean sample
    m_err_mode = 1'b1;
    fir_out = 16'h0055;
    send_sample(16'h0015);
    wait_result(lat);
    chk("err_res_err", result_err, 1);
    chk("err_res_out", result_out, 16'h0055);
    consume();
    m_err_mode = 1'b0;
    fir_out = 16'h0140;
    send_sample(16'h0020);
    wait_result(lat);
    chk("next_res_err", result_err, 0);
    chk("next_res_out", result_out, 16'h0140);
    chk("next_sdata", sample_data, 16'h0020);
    consume();

    // modwait stuck low: dr held TIMEOUT+1 cycles then timeout
    m_stuck = 1'b1;
    send_sample(16'h0030);
    cnt = 0;
    while (dr && cnt < 60) begin cnt++; @(posedge clk); #1; end
    chk("tmo_dr_cycles", cnt, 16);
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_dr", dr, 0);
    chk("tmo_idle", coeff_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("tmo_no_result", result_valid, 0);
    chk("tmo_sticky", timeout_err, 1);

    // reset while in DR_REQ
    send_sample(16'h0040);
    chk("pre_rst_dr", dr, 1);
    @(posedge clk);
    @(negedge clk); n_rst = 1'b0;
    #1;
    chk("arst_dr", dr, 0);
    chk("arst_lc", lc, 0);
    chk("arst_rv", result_valid, 0);
    chk("arst_tmo", timeout_err, 0);
    chk("arst_sdata", sample_data, 0);
    @(negedge clk); n_rst = 1'b1; m_stuck = 1'b0;
    @(posedge clk); #1;
    chk("arst_crdy", coeff_ready, 1);
    chk("arst_srdy", sample_ready, 0);
    chk("arst_dr2", dr, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
